wallace_reduce_pipe: RTL and testbench



---
 rtl/wallace_pkg.sv | 18 +
 rtl/csa_3to2.sv | 14 +
 rtl/wallace_reduce_pipe.sv | 86 ++++++++
 tb/tb_wallace_reduce_pipe.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants for the multiplier datapath: operand/row geometry and the
// fixed Wallace layer schedule used by the reduction pipeline.
package wallace_pkg;
  localparam int W          = 32;
  localparam int PW         = 2 * W;
  localparam int ROWS       = W;
  localparam int NUM_LAYERS = 8;
  localparam int S1_LAYERS  = 4;
  localparam int STAGES     = 3;

  // Rows present before layer 1 and after each layer of 3:2 compression.
  localparam int LAYER_ROWS [NUM_LAYERS+1] = '{32, 22, 15, 10, 7, 5, 4, 3, 2};

  // Row count after one 3:2 layer: each triple yields two rows, leftovers pass.
  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction
endpackage

// File: rtl/csa_3to2.sv
// One PW-bit row of 3:2 carry-save compression; carry out of the MSB is dropped.
module csa_3to2 #(
  parameter int PW = 64
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  input  logic [PW-1:0] c,
  output logic [PW-1:0] sum,
  output logic [PW-1:0] carry
);
  assign sum   = a ^ b ^ c;
  assign carry = {(a[PW-2:0] & b[PW-2:0]) | (a[PW-2:0] & c[PW-2:0]) |
                  (b[PW-2:0] & c[PW-2:0]), 1'b0};
endmodule

// File: rtl/wallace_reduce_pipe.sv
// Three-stage Wallace-tree reduction of W partial-product rows to one PW-bit
// product, with a tag sideband and a global stall enable.
module wallace_reduce_pipe
  import wallace_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W*2*W-1:0]      pp_flat,
  input  logic                  in_valid,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  in_ready,
  output logic [2*W-1:0]        product,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int PW     = 2 * W;
  localparam int S1_N   = LAYER_ROWS[S1_LAYERS];

  logic [W-1:0][PW-1:0]           pp_rows;
  logic [S1_N-1:0][PW-1:0]        s1_rows;
  logic [PW-1:0]                  s2_sum, s2_carry;
  logic [STAGES:1]                vld_pipe;
  logic [STAGES:1][TAG_W-1:0]     tag_pipe;
  logic                           adv;

  assign pp_rows = pp_flat;

  // Layers 1-4 feed the S1 register; layers 5-8 start from it.
  for (genvar l = 1; l <= NUM_LAYERS; l++) begin : g_lyr
    localparam int NI = LAYER_ROWS[l-1];
    localparam int NO = LAYER_ROWS[l];
    localparam int NT = NI / 3;
    logic [NI-1:0][PW-1:0] in_rows;
    logic [NO-1:0][PW-1:0] out_rows;

    if (l == 1) begin : g_src_pp
      assign in_rows = pp_rows;
    end else if (l == S1_LAYERS + 1) begin : g_src_s1
      assign in_rows = s1_rows;
    end else begin : g_src_prev
      assign in_rows = g_lyr[l-1].out_rows;
    end

    for (genvar t = 0; t < NT; t++) begin : g_csa
      csa_3to2 #(.PW(PW)) u_csa (
        .a     (in_rows[3*t]),
        .b     (in_rows[3*t+1]),
        .c     (in_rows[3*t+2]),
        .sum   (out_rows[2*t]),
        .carry (out_rows[2*t+1])
      );
    end

    for (genvar k = 0; k < NI % 3; k++) begin : g_pass
      assign out_rows[2*NT+k] = in_rows[3*NT+k];
    end
  end

  assign adv       = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];

  // Whole pipe moves together; bubbles ride along as invalid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      s1_rows  <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
      product  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      tag_pipe <= {tag_pipe[STAGES-1:1], in_tag};
      s1_rows  <= g_lyr[S1_LAYERS].out_rows;
      s2_sum   <= g_lyr[NUM_LAYERS].out_rows[0];
      s2_carry <= g_lyr[NUM_LAYERS].out_rows[1];
      product  <= s2_sum + s2_carry;
    end
  end
endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Directed bench for wallace_reduce_pipe: latency, corner products,
// back-pressure ordering and mid-stream reset.
module tb_wallace_reduce_pipe;
  localparam int W     = 32;
  localparam int PW    = 64;
  localparam int TAG_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [W*PW-1:0]      pp_flat;
  logic                 in_valid;
  logic [TAG_W-1:0]     in_tag;
  logic                 in_ready;
  logic [PW-1:0]        product;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_valid;
  logic                 out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  wallace_reduce_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_flat   (pp_flat),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .product   (product),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Row i = a << i when bit i of b is set, as the upstream stage produces.
  function automatic logic [W*PW-1:0] build_pp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W*PW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) r[i*PW +: PW] = {32'd0, a} << i;
    return r;
  endfunction

  // Entered #1 after a rising edge with the pipe empty and out_ready high.
  task automatic run_pp(input string nm, input logic [W*PW-1:0] pp,
                        input logic [TAG_W-1:0] tg, input logic [63:0] exp);
    pp_flat = pp; in_tag = tg; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; pp_flat = '0;
    chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat3"}, 64'(out_valid), 64'd1);
    chk({nm, "_prod"}, product, exp);
    chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
    @(posedge clk); #1;
    chk({nm, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [W-1:0] bp_a(input int t);
    return 32'(t * 1000 + 7);
  endfunction
  function automatic logic [W-1:0] bp_b(input int t);
    return 32'hF000_0001 ^ 32'(t << 8);
  endfunction

  initial begin
    logic [63:0] hold_p;
    logic [TAG_W-1:0] hold_t;
    int sent, got, stall_left;
    bit stalled_once;

    rst_n = 1'b0; pp_flat = '0; in_valid = 1'b0; in_tag = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_product",   product,        64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_pp("basic", build_pp(32'd5, 32'd7), 4'd3, 64'd35);
    run_pp("max", build_pp(32'hFFFF_FFFF, 32'hFFFF_FFFF), 4'd5, 64'hFFFF_FFFE_0000_0001);
    run_pp("wrap", '1, 4'd10, 64'hFFFF_FFFF_FFFF_FFE0);

    // Back-pressure: stream tags 1..6, stall 5 cycles when the first result shows.
    sent = 1; got = 1; stall_left = 0; stalled_once = 0;
    hold_p = '0; hold_t = '0;
    for (int cyc = 0; cyc < 60 && got <= 6; cyc++) begin
      if (out_valid && !stalled_once) begin
        stalled_once = 1; stall_left = 5; hold_p = product; hold_t = out_tag;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent <= 6);
      if (sent <= 6) begin
        pp_flat = build_pp(bp_a(sent), bp_b(sent));
        in_tag  = TAG_W'(sent);
      end
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_product", product, hold_p);
        chk("stall_tag", 64'(out_tag), 64'(hold_t));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        chk("bp_tag", 64'(out_tag), 64'(got));
        chk("bp_prod", product, 64'(bp_a(got)) * 64'(bp_b(got)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_all_out", 64'(got), 64'd7);
    chk("bp_stalled", 64'(stalled_once), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Mid-stream reset with three transactions in flight.
    for (int t = 1; t <= 3; t++) begin
      pp_flat = build_pp(32'(t), 32'd11); in_tag = TAG_W'(t); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_full", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_prod",  product, 64'd0);
    chk("mid_rst_tag",   64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_empty", 64'(out_valid), 64'd0);
    end
    run_pp("after_rst", build_pp(32'd3, 32'd3), 4'd9, 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
